rule_sram_rd_arbiter: RTL and testbench
=======================================

RULE_SRAM_RD_ARBITER -- requirements
Module: rule_sram_rd_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of lookup requesters; SRAM_ADDR_WIDTH, default 19, rule-table word address width; SRAM_DATA_WIDTH, default 72, rule word width; TIMEOUT_CYCLES, default 255, read-data watchdog limit.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester read request, held until its ack.
- req_addr  in  NUM_REQ*SRAM_ADDR_WIDTH  flattened addresses; slice i belongs to requester i.
- ack  out  NUM_REQ  one-cycle pulse: request i accepted by SRAM.
- vld  out  NUM_REQ  one-cycle pulse: rd_data valid for requester i.
- err  out  NUM_REQ  one-cycle pulse: read for requester i timed out.
- rd_data  out  SRAM_DATA_WIDTH  returned rule word, shared by all requesters.
- rd_0_req  out  1  SRAM read request.
- rd_0_addr  out  SRAM_ADDR_WIDTH  SRAM read address.
- rd_0_ack  in  1  SRAM accepted the request.
- rd_0_vld  in  1  SRAM read data valid.
- rd_0_data  in  SRAM_DATA_WIDTH  SRAM read data.
- busy  out  1  a transaction is outstanding.

Function
REQ-003 The block SHALL share one SRAM read port among NUM_REQ requesters, one transaction outstanding at a time.
REQ-004 The FSM SHALL have states IDLE, ISSUE and WAIT_VLD.
REQ-005 IDLE: when any req bit is set, the block SHALL select the winner by round-robin from pointer rr_ptr, latch its index and address, and enter ISSUE on the next edge.
REQ-006 ISSUE: rd_0_req SHALL be 1 and rd_0_addr SHALL hold the latched address. rd_0_ack=1 SHALL pulse ack[winner] in the same cycle, drop rd_0_req on the next edge and enter WAIT_VLD.
REQ-007 WAIT_VLD: rd_0_vld=1 SHALL register rd_0_data into rd_data and pulse vld[winner] one cycle later, set rr_ptr to (winner+1) mod NUM_REQ, and return to IDLE.
REQ-008 Latency: a req seen in IDLE at edge N SHALL produce rd_0_req=1 after edge N+1. vld SHALL follow rd_0_vld by exactly one cycle.
REQ-009 rd_0_vld or rd_0_ack outside its own state SHALL be ignored.
REQ-010 rd_0_vld in the cycle after ack SHALL be accepted; the back-to-back case SHALL lose no data.
REQ-011 A requester dropping req before ack SHALL NOT cancel the transaction. Its vld SHALL still pulse.
REQ-012 At most one bit of ack, vld and err SHALL be set in any cycle.
REQ-013 The winner SHALL NOT be re-granted while any other requester is waiting (starvation-free).
REQ-014 busy SHALL be 1 in ISSUE and WAIT_VLD.

Reset
REQ-015 While reset=0 the block SHALL hold: state IDLE, rr_ptr 0, rd_0_req 0, rd_0_addr 0, rd_data 0, and ack, vld, err, busy all 0.
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction with no vld or err pulse. After release, any late rd_0_vld SHALL be ignored under REQ-009.

Configuration
REQ-017 With RULE_ARB_TIMEOUT_EN defined, an 8-bit-minimum counter SHALL run in WAIT_VLD. After TIMEOUT_CYCLES cycles without rd_0_vld it SHALL pulse err[winner], advance rr_ptr and return to IDLE.
REQ-018 Without RULE_ARB_TIMEOUT_EN, WAIT_VLD SHALL wait indefinitely, err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-019 Package rule_sram_arb_pkg SHALL hold the FSM state encoding and the default SRAM_ADDR_WIDTH, SRAM_DATA_WIDTH and TIMEOUT_CYCLES constants.
REQ-020 Round-robin selection SHALL be a combinational sub-module rr_priority_picker with inputs req and rr_ptr and outputs winner index and any_req.

Verification
REQ-021 req=0001, addr0=0x00010, SRAM acks after 2 cycles and gives vld 3 cycles later with data 0x12_3456_789A_BCDE_F012 -> one rd_0_req at 0x00010, ack[0] once, vld[0] with matching rd_data.
REQ-022 req=1111 held continuously, rr_ptr=0 -> grant order 0,1,2,3,0, with no requester served twice in a row.
REQ-023 rd_0_vld in the cycle right after rd_0_ack, then req[2] raised immediately -> vld correct and the next rd_0_req issued 2 cycles after vld.
REQ-024 reset driven low in WAIT_VLD, then a stray rd_0_vld after release -> no vld or err, state IDLE, rr_ptr 0.
REQ-025 With RULE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rd_0_vld -> err[winner] after 8 WAIT_VLD cycles and the next requester served. Without the macro -> busy stays 1 and err stays 0.

Source files
------------

// File: rtl/rule_sram_arb_pkg.sv
// Shared constants and FSM encoding for the rule-table SRAM read arbiter.
package rule_sram_arb_pkg;

    localparam int DEF_SRAM_ADDR_WIDTH = 19;
    localparam int DEF_SRAM_DATA_WIDTH = 72;
    localparam int DEF_TIMEOUT_CYCLES  = 255;
    localparam int MIN_TIMEOUT_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_VLD = 2'd2
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, wrapping
// around NUM_REQ.
module rr_priority_picker
    import rule_sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic found;
    int   idx;

    always_comb begin
        // NOTE: every variable gets a value before the loop so no latch is inferred.
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rule_sram_rd_arbiter.sv
// Round-robin arbiter sharing one rule-table SRAM read port among NUM_REQ requesters.
// Optional read-data watchdog is compiled in when RULE_ARB_TIMEOUT_EN is defined.
module rule_sram_rd_arbiter
    import rule_sram_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
    parameter int SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]                 ack,
    output logic [NUM_REQ-1:0]                 vld,
    output logic [NUM_REQ-1:0]                 err,
    output logic [SRAM_DATA_WIDTH-1:0]         rd_data,
    output logic                               rd_0_req,
    output logic [SRAM_ADDR_WIDTH-1:0]         rd_0_addr,
    input  logic                               rd_0_ack,
    input  logic                               rd_0_vld,
    input  logic [SRAM_DATA_WIDTH-1:0]         rd_0_data,
    output logic                               busy
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e                 state_q, state_d;
    logic                       pend_q, pend_d;
    logic [IDX_W-1:0]           win_q, win_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_REQ-1:0]         vld_q, vld_d;

    logic [IDX_W-1:0]           pick_idx;
    logic                       pick_any;
    logic [NUM_REQ-1:0]         win_onehot;
    logic [IDX_W-1:0]           next_ptr;

`ifdef RULE_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > MIN_TIMEOUT_CNT_W) ?
                           $clog2(TIMEOUT_CYCLES + 1) : MIN_TIMEOUT_CNT_W;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_REQ-1:0]         err_q, err_d;
`endif

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    assign win_onehot = NUM_REQ'(1) << win_q;
    assign next_ptr   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        win_d     = win_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
        vld_d     = '0;
        ack       = '0;
`ifdef RULE_ARB_TIMEOUT_EN
        err_d     = '0;
        cnt_d     = '0;
`endif
        unique case (state_q)
            IDLE: begin
                // Winner and address are captured one edge ahead of ISSUE, so the
                // SRAM address comes straight from a register when rd_0_req rises.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ISSUE;
                end else if (pick_any) begin
                    pend_d = 1'b1;
                    win_d  = pick_idx;
                    addr_d = req_addr[pick_idx*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
                end
            end
            ISSUE: begin
                if (rd_0_ack) begin
                    ack     = win_onehot;
                    state_d = WAIT_VLD;
                end
            end
            WAIT_VLD: begin
                if (rd_0_vld) begin
                    rd_data_d = rd_0_data;
                    vld_d     = win_onehot;
                    rr_ptr_d  = next_ptr;
                    state_d   = IDLE;
                end
`ifdef RULE_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d    = win_onehot;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            win_q     <= '0;
            rr_ptr_q  <= '0;
            addr_q    <= '0;
            rd_data_q <= '0;
            vld_q     <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q   <= state_d;
            pend_q    <= pend_d;
            win_q     <= win_d;
            rr_ptr_q  <= rr_ptr_d;
            addr_q    <= addr_d;
            rd_data_q <= rd_data_d;
            vld_q     <= vld_d;
        end
    end

`ifdef RULE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

    assign rd_0_req  = (state_q == ISSUE);
    assign rd_0_addr = addr_q;
    assign rd_data   = rd_data_q;
    assign vld       = vld_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rule_sram_rd_arbiter.sv
// Self-checking bench for rule_sram_rd_arbiter: directed scenarios plus randomized
// traffic against a round-robin reference model. Define RULE_ARB_TIMEOUT_EN to cover the watchdog.
module tb_rule_sram_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 72;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [AW-1:0]   addr_tbl [N];
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    ack, vld, err;
    logic [DW-1:0]   rd_data;
    logic            rd_0_req;
    logic [AW-1:0]   rd_0_addr;
    logic            rd_0_ack, rd_0_vld;
    logic [DW-1:0]   rd_0_data;
    logic            busy;

    int checks    = 0;
    int errors    = 0;
    int model_ptr = 0;
    bit stray_en  = 1'b0;

    always #5 clk = ~clk;

    assign req_addr = {addr_tbl[3], addr_tbl[2], addr_tbl[1], addr_tbl[0]};

    rule_sram_rd_arbiter #(
        .NUM_REQ         (N),
        .SRAM_ADDR_WIDTH (AW),
        .SRAM_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .ack       (ack),
        .vld       (vld),
        .err       (err),
        .rd_data   (rd_data),
        .rd_0_req  (rd_0_req),
        .rd_0_addr (rd_0_addr),
        .rd_0_ack  (rd_0_ack),
        .rd_0_vld  (rd_0_vld),
        .rd_0_data (rd_0_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first requester found walking circularly from the pointer.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic wait_req(input int w, input int exp_lat);
        int n;
        n = 0;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            @(negedge clk); #1;
            if (rd_0_req) n = i;
            else check("pulses_quiet_before_issue", {ack, vld, err}, '0);
        end
        check("rd_0_req_seen", n != 0, 1'b1);
        if (exp_lat > 0) check("issue_latency", n, exp_lat);
        check("rd_0_addr", rd_0_addr, addr_tbl[w]);
        check("busy_issue", busy, 1'b1);
    endtask

    task automatic do_ack(input int w, input int ack_dly, input bit drop);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            rd_0_ack = 1'b0;
            rd_0_vld = stray_en & 1'($urandom % 2);
            #1;
            check("ack_idle_in_issue", ack, '0);
            check("rd_0_req_held", rd_0_req, 1'b1);
        end
        @(negedge clk);
        rd_0_ack = 1'b1;
        rd_0_vld = stray_en & 1'($urandom % 2);
        #1;
        check("ack_onehot", ack, 128'd1 << w);
        if (drop) req[w] = 1'b0;
    endtask

    task automatic do_vld(input int w, input int vld_dly, input logic [DW-1:0] data);
        for (int i = 0; i < vld_dly; i++) begin
            @(negedge clk);
            rd_0_ack = stray_en & 1'($urandom % 2);
            rd_0_vld = 1'b0;
            #1;
            check("wait_quiet", {ack, vld, err}, '0);
            check("busy_wait", busy, 1'b1);
            check("rd_0_req_dropped", rd_0_req, 1'b0);
        end
        @(negedge clk);
        rd_0_ack  = 1'b0;
        rd_0_vld  = 1'b1;
        rd_0_data = data;
        #1;
        check("vld_not_early", vld, '0);
        @(negedge clk);
        rd_0_vld  = 1'b0;
        rd_0_data = rand_word();
        #1;
        check("vld_onehot", vld, 128'd1 << w);
        check("rd_data", rd_data, data);
        check("busy_after_vld", busy, 1'b0);
        check("err_after_vld", err, '0);
        model_ptr = (w + 1) % N;
    endtask

    task automatic serve(input int w, input int ack_dly, input int vld_dly,
                         input logic [DW-1:0] data, input bit drop);
        wait_req(w, 2);
        do_ack(w, ack_dly, drop);
        do_vld(w, vld_dly, data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            w;
        logic [N-1:0]  r, old;
        logic [DW-1:0] d;

        // Reset holds everything quiet even with live stimulus.
        reset     = 1'b0;
        req       = '1;
        rd_0_ack  = 1'b1;
        rd_0_vld  = 1'b1;
        rd_0_data = '1;
        for (int j = 0; j < N; j++) addr_tbl[j] = AW'($urandom);
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rd_0_req", rd_0_req, 1'b0);
        check("rst_rd_0_addr", rd_0_addr, '0);
        check("rst_rd_data", rd_data, '0);
        check("rst_pulses", {ack, vld, err}, '0);
        @(negedge clk);
        reset    = 1'b1;
        req      = '0;
        rd_0_ack = 1'b0;
        rd_0_vld = 1'b0;
        @(negedge clk);

        // Single read from requester 0.
        addr_tbl[0] = 19'h00010;
        req = 4'b0001;
        serve(0, 1, 2, 72'h12_3456_789A_BCDE_F012, 1'b1);

        // SRAM handshakes while idle must be ignored.
        req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_0_ack  = 1'b1;
            rd_0_vld  = 1'b1;
            rd_0_data = rand_word();
            #1;
            check("idle_stray_pulses", {ack, vld, err}, '0);
            check("idle_stray_busy", {busy, rd_0_req}, '0);
        end
        check("idle_stray_rd_data", rd_data, 72'h12_3456_789A_BCDE_F012);
        @(negedge clk);
        rd_0_ack = 1'b0;
        rd_0_vld = 1'b0;

        // Bring the pointer to 0, then all four requesters held continuously.
        req = 4'b1000;
        serve(3, 0, 1, rand_word(), 1'b1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = k % N;
            serve(w, k % 2, (k + 1) % 3, rand_word(), 1'b0);
        end

        // Requester withdraws before ack; the read still completes.
        req = 4'b0100;
        wait_req(2, 2);
        req = '0;
        do_ack(2, 2, 1'b0);
        do_vld(2, 1, rand_word());

        // Back-to-back: vld right after ack, next request raised on the vld cycle.
        req = 4'b0010;
        w = model_pick(req, model_ptr);
        serve(w, 0, 0, rand_word(), 1'b1);
        req = 4'b0100;
        serve(2, 0, 0, rand_word(), 1'b1);

        // Randomized traffic with stray SRAM handshakes.
        stray_en = 1'b1;
        for (int t = 0; t < 24; t++) begin
            old = req;
            r   = N'($urandom);
            for (int j = 0; j < N; j++)
                if (r[j] && !old[j]) addr_tbl[j] = AW'($urandom);
            req = old | r;
            if (req == '0) req = 4'b0001;
            w = model_pick(req, model_ptr);
            d = rand_word();
            serve(w, $urandom_range(3, 0), $urandom_range(3, 0), d, 1'b1);
        end
        stray_en = 1'b0;

        req = 4'b0001;
        serve(0, 0, 0, rand_word(), 1'b1);

`ifdef RULE_ARB_TIMEOUT_EN
        // Watchdog: no read data for 8 cycles.
        req = 4'b0011;
        w = model_pick(req, model_ptr);
        wait_req(w, 2);
        do_ack(w, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_0_ack = 1'b0;
            rd_0_vld = 1'b0;
            #1;
            check("tmo_busy_wait", busy, 1'b1);
            check("tmo_err_quiet", err, '0);
        end
        @(negedge clk); #1;
        check("tmo_err_onehot", err, 128'd1 << w);
        check("tmo_vld_quiet", vld, '0);
        check("tmo_busy_clear", busy, 1'b0);
        model_ptr = (w + 1) % N;
        w = model_pick(req, model_ptr);
        serve(w, 0, 1, rand_word(), 1'b1);
        req = 4'b0100;
        wait_req(2, 2);
        do_ack(2, 0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            rd_0_ack = 1'b0;
            rd_0_vld = 1'b0;
        end
`else
        // No watchdog: WAIT_VLD holds indefinitely.
        req = 4'b0100;
        wait_req(2, 2);
        do_ack(2, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rd_0_ack = 1'b0;
            rd_0_vld = 1'b0;
            #1;
            check("hang_busy", busy, 1'b1);
            check("hang_pulses", {vld, err}, '0);
        end
`endif

        // Reset while waiting for read data, then a late rd_0_vld.
        @(negedge clk);
        reset    = 1'b0;
        rd_0_ack = 1'b0;
        rd_0_vld = 1'b0;
        req      = '0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_rd_0_req", rd_0_req, 1'b0);
        check("midrst_rd_0_addr", rd_0_addr, '0);
        check("midrst_rd_data", rd_data, '0);
        check("midrst_pulses", {ack, vld, err}, '0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        rd_0_vld  = 1'b1;
        rd_0_data = rand_word();
        @(negedge clk);
        rd_0_vld = 1'b0;
        #1;
        check("late_vld_pulses", {vld, err}, '0);
        check("late_vld_busy", busy, 1'b0);
        check("late_vld_rd_data", rd_data, '0);
        model_ptr = 0;
        req = 4'b1111;
        w = model_pick(req, model_ptr);
        serve(w, 1, 1, rand_word(), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
